// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipe_ctrl_pkg: shared encodings and types for the pipeline controller      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package pipe_ctrl_pkg;

  localparam logic       PIPE_ST_RUN      = 1'b0;
  localparam logic       PIPE_ST_ACC_WAIT = 1'b1;
  localparam logic [4:0] REG_ZERO         = 5'd0;

  typedef enum logic [0:0] {
    ST_RUN      = PIPE_ST_RUN,
    ST_ACC_WAIT = PIPE_ST_ACC_WAIT
  } pipe_state_e;

  typedef struct packed {
    logic stall_if;
    logic stall_id;
    logic bubble_id;
    logic stall_ex;
    logic bubble_ex;
    logic stall_mem;
    logic bubble_mem;
    logic stall_wb;
    logic bubble_wb;
  } pipe_ctrl_t;

  function automatic logic is_load_use(
    input logic       mem_read_ex,
    input logic [4:0] rd_ex,
    input logic [4:0] rs1_id,
    input logic       rs1_used_id,
    input logic [4:0] rs2_id,
    input logic       rs2_used_id
  );
    return mem_read_ex && (rd_ex != REG_ZERO) &&
           ((rs1_used_id && (rs1_id == rd_ex)) ||
            (rs2_used_id && (rs2_id == rd_ex)));
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipe_ctrl_if: hazard inputs and stall/bubble controls of the pipeline      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface pipe_ctrl_if;
  logic [4:0] rs1_id;
  logic [4:0] rs2_id;
  logic       rs1_used_id;
  logic       rs2_used_id;
  logic [4:0] rd_ex;
  logic       mem_read_ex;
  logic       branch_taken_ex;
  logic       acc_op_ex;
  logic       acc_done;
  logic       acc_go;
  logic       imem_ready;
  logic       dmem_req_mem;
  logic       dmem_ready;
  logic       stall_if;
  logic       stall_id;
  logic       bubble_id;
  logic       stall_ex;
  logic       bubble_ex;
  logic       stall_mem;
  logic       bubble_mem;
  logic       stall_wb;
  logic       bubble_wb;
  logic       acc_busy;
  logic       acc_timeout;

  // master: pipeline/accelerator side; slave: the controller
  modport master (
    output rs1_id, rs2_id, rs1_used_id, rs2_used_id, rd_ex, mem_read_ex,
           branch_taken_ex, acc_op_ex, acc_done, imem_ready, dmem_req_mem, dmem_ready,
    input  acc_go, stall_if, stall_id, bubble_id, stall_ex, bubble_ex, stall_mem,
           bubble_mem, stall_wb, bubble_wb, acc_busy, acc_timeout
  );

  modport slave (
    input  rs1_id, rs2_id, rs1_used_id, rs2_used_id, rd_ex, mem_read_ex,
           branch_taken_ex, acc_op_ex, acc_done, imem_ready, dmem_req_mem, dmem_ready,
    output acc_go, stall_if, stall_id, bubble_id, stall_ex, bubble_ex, stall_mem,
           bubble_mem, stall_wb, bubble_wb, acc_busy, acc_timeout
  );
endinterface
`default_nettype wire

// File: rtl/pipe_ctrl_wdt.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipe_ctrl_wdt: accelerator-wait watchdog counter and expiry compare        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pipe_ctrl_wdt #(
  parameter int ACC_TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic enter,
  input  logic active,
  input  logic acc_done,
  output logic wdt_expire
);

  localparam int              CW       = $clog2(ACC_TIMEOUT + 1);
  localparam logic [CW-1:0]   C_LAST   = CW'(ACC_TIMEOUT - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (enter) begin
      r_cnt <= '0;
    end else if (active) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign wdt_expire = active && !acc_done && (r_cnt == C_LAST);

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipe_ctrl: pipeline stall/bubble controller with accelerator handshake     |
// | Optional watchdog: define PIPE_CTRL_ACC_WDT_EN                             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int ACC_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.slave  bus
);

  pipe_state_e r_state;
  pipe_ctrl_t  w_ctrl;
  logic        w_run;
  logic        w_wait;
  logic        w_dmem_hold;
  logic        w_acc_hold;
  logic        w_load_use;
  logic        w_go;
  logic        w_wdt_expire;

  assign w_run       = (r_state == ST_RUN);
  assign w_wait      = (r_state == ST_ACC_WAIT);
  assign w_dmem_hold = bus.dmem_req_mem && !bus.dmem_ready;
  assign w_go        = w_run && bus.acc_op_ex && !bus.acc_done && !w_dmem_hold;
  assign w_acc_hold  = (w_run && bus.acc_op_ex && !bus.acc_done) ||
                       (w_wait && !bus.acc_done && !w_wdt_expire);
  assign w_load_use  = is_load_use(bus.mem_read_ex, bus.rd_ex, bus.rs1_id,
                                   bus.rs1_used_id, bus.rs2_id, bus.rs2_used_id);

`ifdef PIPE_CTRL_ACC_WDT_EN
  pipe_ctrl_wdt #(
    .ACC_TIMEOUT (ACC_TIMEOUT)
  ) u_wdt (
    .clk        (clk),
    .rst        (rst),
    .enter      (w_go),
    .active     (w_wait),
    .acc_done   (bus.acc_done),
    .wdt_expire (w_wdt_expire)
  );
`else
  logic unused_acc_timeout;
  assign unused_acc_timeout = (ACC_TIMEOUT > 0);
  assign w_wdt_expire       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_RUN;
    end else begin
      case (r_state)
        ST_RUN:      if (w_go) r_state <= ST_ACC_WAIT;
        ST_ACC_WAIT: if (bus.acc_done || w_wdt_expire) r_state <= ST_RUN;
        default:     r_state <= ST_RUN;
      endcase
    end
  end

  // Priority mux: first matching hazard wins, all other controls stay low
  always_comb begin
    w_ctrl = '0;
    if (!rst) begin
      w_ctrl = '0;
    end else if (w_dmem_hold) begin
      w_ctrl.stall_if  = 1'b1;
      w_ctrl.stall_id  = 1'b1;
      w_ctrl.stall_ex  = 1'b1;
      w_ctrl.stall_mem = 1'b1;
      w_ctrl.bubble_wb = 1'b1;
    end else if (w_acc_hold) begin
      w_ctrl.stall_if   = 1'b1;
      w_ctrl.stall_id   = 1'b1;
      w_ctrl.stall_ex   = 1'b1;
      w_ctrl.bubble_mem = 1'b1;
    end else if (bus.branch_taken_ex) begin
      w_ctrl.bubble_id = 1'b1;
      w_ctrl.bubble_ex = 1'b1;
    end else if (w_load_use) begin
      w_ctrl.stall_if  = 1'b1;
      w_ctrl.stall_id  = 1'b1;
      w_ctrl.bubble_ex = 1'b1;
    end else if (!bus.imem_ready) begin
      w_ctrl.stall_if  = 1'b1;
      w_ctrl.bubble_id = 1'b1;
    end
  end

  assign bus.stall_if    = w_ctrl.stall_if;
  assign bus.stall_id    = w_ctrl.stall_id;
  assign bus.bubble_id   = w_ctrl.bubble_id;
  assign bus.stall_ex    = w_ctrl.stall_ex;
  assign bus.bubble_ex   = w_ctrl.bubble_ex;
  assign bus.stall_mem   = w_ctrl.stall_mem;
  assign bus.bubble_mem  = w_ctrl.bubble_mem;
  assign bus.stall_wb    = w_ctrl.stall_wb;
  assign bus.bubble_wb   = w_ctrl.bubble_wb;
  assign bus.acc_go      = rst && w_go;
  assign bus.acc_busy    = rst && w_wait;
  assign bus.acc_timeout = rst && w_wait && w_wdt_expire;

endmodule
`default_nettype wire
